// File: rtl/vm_input_conditioner.sv
// -----------------------------------------------------------------------------
// vm_input_conditioner
//
// Front-end between the vending-machine panel pins and fsm_top. Each of the
// four raw inputs is passed through a 2-flop synchroniser and a counting
// debouncer. Coin and accept are turned into single-cycle strobes on their
// debounced rising edges; the two reset buttons are passed on as debounced
// levels.
//
// Optional feature macro: COIN_LOCKOUT_EN
//   When defined, every emitted coin strobe starts a LOCKOUT_CYCLES-long
//   lockout during which further debounced coin rising edges are dropped.
//   When undefined, there is no lockout counter and coin_locked is 0.
//
// Parameters:
//   DB_CYCLES      - consecutive disagreeing cycles to accept a level change
//                    (1..65535)
//   LOCKOUT_CYCLES - coin re-trigger lockout length (1..255)
//
// Ports:
//   clk          - clock, all state changes on the rising edge
//   rst          - synchronous active-high reset
//   ena          - block enable; 0 freezes debounce/lockout state and
//                  forces both strobes low
//   raw_in[3:0]  - asynchronous panel inputs: [0] coin, [1] accept,
//                  [2] Moore reset button, [3] Mealy reset button
//   coin_pulse   - one-cycle strobe per debounced coin press (FSM m)
//   accept_pulse - one-cycle strobe per debounced accept press (FSM a)
//   moore_rst    - debounced level of raw_in[2] (FSM btnC)
//   mealy_rst    - debounced level of raw_in[3] (FSM btnD)
//   coin_locked  - high while the coin lockout counter is nonzero
// -----------------------------------------------------------------------------
module vm_input_conditioner #(
    parameter int DB_CYCLES      = 16,
    parameter int LOCKOUT_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [3:0] raw_in,
    output logic       coin_pulse,
    output logic       accept_pulse,
    output logic       moore_rst,
    output logic       mealy_rst,
    output logic       coin_locked
);

    localparam int            CW       = $clog2(DB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [3:0]    s1;
    logic [3:0]    s2;
    logic [3:0]    stable;
    logic [1:0]    stable_d;   // only the two edge-detected channels need history
    logic [CW-1:0] cnt [4];
    logic          coin_rise;
    logic          accept_rise;
    logic          lock_idle;

    // Stage: two-flop synchroniser (keeps sampling even when disabled)
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 4'b0;
            s2 <= 4'b0;
        end else begin
            s1 <= raw_in;
            s2 <= s1;
        end
    end

    // Stage: per-channel debouncer; any agreeing cycle restarts the count
    always_ff @(posedge clk) begin
        if (rst) begin
            stable   <= 4'b0;
            stable_d <= 2'b0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else if (ena) begin
            stable_d <= stable[1:0];
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign coin_rise   = stable[0] & ~stable_d[0];
    assign accept_rise = stable[1] & ~stable_d[1];

`ifdef COIN_LOCKOUT_EN
    localparam logic [7:0] LOCK_LOAD = 8'(LOCKOUT_CYCLES);

    logic [7:0] lock_cnt;

    // A coin edge is emitted only when idle, so loading here coincides
    // exactly with the coin_pulse register being set.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt <= 8'd0;
        end else if (ena) begin
            if (coin_rise && lock_cnt == 8'd0) begin
                lock_cnt <= LOCK_LOAD;
            end else if (lock_cnt != 8'd0) begin
                lock_cnt <= lock_cnt - 8'd1;
            end
        end
    end

    assign lock_idle   = (lock_cnt == 8'd0);
    assign coin_locked = ~lock_idle;
`else
    assign lock_idle   = 1'b1;
    assign coin_locked = 1'b0;
`endif

    // Stage: registered edge strobes; rising edges seen while locked are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            coin_pulse   <= 1'b0;
            accept_pulse <= 1'b0;
        end else if (!ena) begin
            coin_pulse   <= 1'b0;
            accept_pulse <= 1'b0;
        end else begin
            coin_pulse   <= coin_rise & lock_idle;
            accept_pulse <= accept_rise;
        end
    end

    assign moore_rst = stable[2];
    assign mealy_rst = stable[3];

endmodule
